alu_result_stage: RTL

//  Pipeline stage directly downstream of the 16-bit ALU datapath (adder/subtractor/logic).

---
 rtl/alu_result_stage_pkg.sv | 34 +++
 rtl/alu_result_stage_if.sv | 29 ++
 rtl/alu_result_stage_flag_gen.sv | 36 +++
 rtl/alu_result_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: op codes, flag bit positions,
// datapath widths and the buffered entry layout.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int RD_W  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOGIC = 2'b10,
    OP_PASS  = 2'b11
  } op_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [RD_W-1:0]  rd;
    logic             wen;
    logic [3:0]       flags;
  } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between ALU (producer), result stage and writeback (consumer).
interface alu_result_stage_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_ans;
  logic [1:0]       in_op;
  logic [RD_W-1:0]  in_rd;
  logic             in_wen;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [RD_W-1:0]  out_rd;
  logic             out_wen;

  modport master (
    output in_valid, in_a, in_b, in_ans, in_op, in_rd, in_wen, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_wen
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ans, in_op, in_rd, in_wen, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_wen
  );

endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational Z/N/C/V derivation from the ALU operands and its trusted result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] ans,
  input  logic [1:0]   op,
  output logic [3:0]   zncv
);

  // flag decode per operation class
  always_comb begin
    zncv        = 4'b0000;
    zncv[FLG_Z] = (ans == {W{1'b0}});
    zncv[FLG_N] = ans[W-1];
    case (op)
      OP_ADD: begin
        // a + b carries out exactly when a exceeds the headroom ~b
        zncv[FLG_C] = (a > ~b);
        zncv[FLG_V] = (a[W-1] == b[W-1]) && (ans[W-1] != a[W-1]);
      end
      OP_SUB: begin
        zncv[FLG_C] = (a < b);
        zncv[FLG_V] = (a[W-1] != b[W-1]) && (ans[W-1] != a[W-1]);
      end
      default: begin
        zncv[FLG_C] = 1'b0;
        zncv[FLG_V] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: flag capture, 2-entry skid FIFO toward writeback,
// architectural flag register and retired-result counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_stage_if.slave  bus,
  output logic [3:0]         flags,
  output logic [CNT_W_P-1:0] retired
);

  occ_state_e         state_r;
  occ_state_e         state_nxt_s;
  entry_t             mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [3:0]         flags_r;
  logic [CNT_W_P-1:0] retired_r;
  logic [3:0]         zncv_s;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               pop_s;

  alu_flag_gen #(.W(WIDTH)) u_flag_gen (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .ans  (bus.in_ans),
    .op   (bus.in_op),
    .zncv (zncv_s)
  );

  // occupancy state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // occupancy next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: state_nxt_s = push_s ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (push_s && !pop_s) begin
          state_nxt_s = ST_FULL;
        end else if (pop_s && !push_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL:  state_nxt_s = pop_s ? ST_ONE : ST_FULL;
      default:  state_nxt_s = ST_EMPTY;
    endcase
  end

  // handshake decode from registered state only; out_ready never reaches in_ready
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_ONE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b1;
      end
      ST_FULL: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
    push_s = bus.in_valid && in_ready_s;
    pop_s  = out_valid_s && bus.out_ready;
  end

  // entry storage, pointers, architectural flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      flags_r   <= 4'b0000;
      retired_r <= {CNT_W_P{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{data: bus.in_ans, rd: bus.in_rd,
                             wen: bus.in_wen, flags: zncv_s};
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r  <= ~rd_ptr_r;
        flags_r   <= mem_r[rd_ptr_r].flags;
        retired_r <= retired_r + CNT_W_P'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = mem_r[rd_ptr_r].data;
  assign bus.out_rd    = mem_r[rd_ptr_r].rd;
  assign bus.out_wen   = mem_r[rd_ptr_r].wen;
  assign flags         = flags_r;
  assign retired       = retired_r;

endmodule
